// File: rtl/mux_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux scheduler.
package mux_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [N_IN-1:0] onehot_from_idx(input logic [SEL_W-1:0] idx);
    logic [N_IN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_8to1.sv
// Plain 8:1 bit multiplexer that the scheduler shares among its requesters.
module mux_8to1
  import mux_pkg::*;
(
  input  logic [N_IN-1:0]  din,
  input  logic [SEL_W-1:0] sel,
  output logic             dout
);

  assign dout = din[sel];

endmodule

// File: rtl/mux_rr_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping.
// Rotate so start lands at bit 0, take the lowest set bit, then rotate the index back.
module mux_rr_pick
  import mux_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_IN-1:0]  rot;
  logic [SEL_W-1:0] pos;

  // rot[j] is the requester j places after start (indices wrap naturally at 3 bits)
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_rot
      assign rot[gi] = req[SEL_W'(gi) + start];
    end
  endgenerate

  // Priority encode: lowest rotated position wins
  always_comb begin
    pos = '0;
    for (int j = N_IN - 1; j >= 0; j--) begin
      if (rot[j]) pos = SEL_W'(j);
    end
  end

  assign found = |req;
  assign idx   = pos + start;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler owning the select of an 8:1 bit mux, with a bounded hold
// time per grant so no requester can starve the others.
module mux_rr_sched
  import mux_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req,
  input  logic [N_IN-1:0]  din,
  output logic [N_IN-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             gnt_valid,
  output logic             switch,
  output logic             dout
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] owner_reg, owner_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [N_IN-1:0]  gnt_reg, gnt_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic             gnt_valid_reg, gnt_valid_next;
  logic             switch_reg, switch_next;

  logic [SEL_W-1:0] pick_start;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             grant_end;
  logic             regrant;

  // Search begins just after the owner, so the owner itself is considered last.
  // That single ordering covers both release (owner bit is 0) and timeout
  // (owner only wins again when nobody else is asking).
  assign pick_start = owner_reg + 3'd1;

  mux_rr_pick u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Release and timeout both just end the grant, so coincidence needs no special case
  assign grant_end = (state_reg == IDLE) || !req[owner_reg] || (cnt_reg == HOLD_LIM);
  assign regrant   = grant_end && pick_found;

  // State register: all scheduler state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= 3'd7;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      sel_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      switch_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      cnt_reg       <= cnt_next;
      gnt_reg       <= gnt_next;
      sel_reg       <= sel_next;
      gnt_valid_reg <= gnt_valid_next;
      switch_reg    <= switch_next;
    end
  end

  // Next-state: pick a new owner when a grant ends, otherwise count hold cycles
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    if (regrant) begin
      state_next = BUSY;
      owner_next = pick_idx;
      cnt_next   = 8'd1;
    end else if (grant_end) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      cnt_next   = cnt_reg + 8'd1;
    end
  end

  // Output decode: registered grant/select follow the chosen owner; sel holds while idle
  always_comb begin
    gnt_next       = gnt_reg;
    sel_next       = sel_reg;
    gnt_valid_next = gnt_valid_reg;
    switch_next    = 1'b0;
    if (regrant) begin
      gnt_next       = onehot_from_idx(pick_idx);
      sel_next       = pick_idx;
      gnt_valid_next = 1'b1;
      switch_next    = 1'b1;
    end else if (grant_end) begin
      gnt_next       = '0;
      gnt_valid_next = 1'b0;
    end
  end

  assign gnt       = gnt_reg;
  assign sel       = sel_reg;
  assign gnt_valid = gnt_valid_reg;
  assign switch    = switch_reg;

  mux_8to1 u_mux (
    .din  (din),
    .sel  (sel_reg),
    .dout (dout)
  );

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: three instances (HOLD_MAX 16, 4, 3) share one request
// stream; a behavioural model pushes expected outputs to a queue per cycle and the
// sampled DUT outputs are popped and compared one cycle later.
module tb_mux_rr_sched;

  localparam int NI = 3;

  logic clk;
  logic rst_n;
  logic [7:0] req;
  logic [7:0] din;

  logic [NI-1:0][7:0] gnt;
  logic [NI-1:0][2:0] sel;
  logic [NI-1:0]      gv;
  logic [NI-1:0]      sw;
  logic [NI-1:0]      dout;

  typedef struct packed {
    logic [NI-1:0][7:0] gnt;
    logic [NI-1:0][2:0] sel;
    logic [NI-1:0]      gv;
    logic [NI-1:0]      sw;
  } exp_t;

  exp_t sbq[$];
  exp_t m_out;
  logic [NI-1:0] m_busy;
  int m_owner[NI];
  int m_cnt[NI];
  int hold_tab[NI];

  int total;
  int bad;
  int cyc;

  mux_rr_sched #(.HOLD_MAX(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt[0]), .sel(sel[0]), .gnt_valid(gv[0]), .switch(sw[0]), .dout(dout[0])
  );
  mux_rr_sched #(.HOLD_MAX(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt[1]), .sel(sel[1]), .gnt_valid(gv[1]), .switch(sw[1]), .dout(dout[1])
  );
  mux_rr_sched #(.HOLD_MAX(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt[2]), .sel(sel[2]), .gnt_valid(gv[2]), .switch(sw[2]), .dout(dout[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      m_busy[k]  = 1'b0;
      m_owner[k] = 7;
      m_cnt[k]   = 0;
    end
    m_out = '0;
  endfunction

  // Reference behaviour: linear search from owner+1, owner examined last
  function automatic void model_step(input logic [7:0] r);
    bit found;
    int nxt;
    int c;
    for (int k = 0; k < NI; k++) begin
      m_out.sw[k] = 1'b0;
      if (!m_busy[k] || !r[m_owner[k]] || m_cnt[k] == hold_tab[k]) begin
        found = 0;
        nxt   = 0;
        for (int i = 1; i <= 8; i++) begin
          c = (m_owner[k] + i) % 8;
          if (!found && r[c]) begin
            found = 1;
            nxt   = c;
          end
        end
        if (found) begin
          m_busy[k]     = 1'b1;
          m_owner[k]    = nxt;
          m_cnt[k]      = 1;
          m_out.gnt[k]  = 8'(1 << nxt);
          m_out.sel[k]  = 3'(nxt);
          m_out.gv[k]   = 1'b1;
          m_out.sw[k]   = 1'b1;
        end else begin
          m_busy[k]     = 1'b0;
          m_cnt[k]      = 0;
          m_out.gnt[k]  = 8'h00;
          m_out.gv[k]   = 1'b0;
        end
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endfunction

  task automatic compare();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(e.gnt[k]));
        chk($sformatf("sel%0d", k), 32'(sel[k]), 32'(e.sel[k]));
        chk($sformatf("valid%0d", k), 32'(gv[k]), 32'(e.gv[k]));
        chk($sformatf("switch%0d", k), 32'(sw[k]), 32'(e.sw[k]));
        if (e.gv[k]) chk($sformatf("dout%0d", k), 32'(dout[k]), 32'(din[e.sel[k]]));
      end
    end
  endtask

  // One transaction: drive req/din, queue the expectation, sample after the edge
  task automatic cycle(input logic [7:0] r);
    req = r;
    din = 8'($urandom);
    model_step(r);
    sbq.push_back(m_out);
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d req=%02h gnt=%02h/%02h/%02h sel=%0d/%0d/%0d sw=%b", cyc, r,
             gnt[0], gnt[1], gnt[2], sel[0], sel[1], sel[2], sw);
    compare();
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_gnt%0d", tag, k), 32'(gnt[k]), 32'h0);
      chk($sformatf("%s_sel%0d", tag, k), 32'(sel[k]), 32'h0);
      chk($sformatf("%s_valid%0d", tag, k), 32'(gv[k]), 32'h0);
      chk($sformatf("%s_switch%0d", tag, k), 32'(sw[k]), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    hold_tab[0] = 16;
    hold_tab[1] = 4;
    hold_tab[2] = 3;

    // Reset with every requester asking
    rst_n = 1'b0;
    req   = 8'hFF;
    din   = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_cleared("rst");
    rst_n = 1'b1;
    cycle(8'hFF);
    chk("first_gnt", 32'(gnt[0]), 32'h01);
    chk("first_sel", 32'(sel[0]), 32'h0);
    chk("first_switch", 32'(sw[0]), 32'h1);
    repeat (6) cycle(8'hFF);

    // Single requester 5 for five cycles, then idle
    repeat (2) cycle(8'h00);
    repeat (5) cycle(8'h20);
    chk("r5_sel", 32'(sel[0]), 32'd5);
    cycle(8'h00);
    chk("r5_valid_drop", 32'(gv[0]), 32'h0);
    cycle(8'h00);

    // Two steady requesters: timeout-driven alternation
    repeat (17) cycle(8'h81);
    repeat (2) cycle(8'h00);

    // Lone requester re-granted at every timeout
    repeat (10) cycle(8'h08);
    repeat (2) cycle(8'h00);

    // Owner 2 releases while 1 and 6 arrive: wrap from 3 finds 6 first
    repeat (2) cycle(8'h04);
    cycle(8'h42);
    chk("wrap_pick", 32'(gnt[0]), 32'h40);
    repeat (2) cycle(8'h00);

    // Random sparse traffic
    repeat (250) cycle(8'($urandom & $urandom));
    repeat (2) cycle(8'h00);

    // Asynchronous reset mid-grant (owner 4, counter 2)
    repeat (2) cycle(8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    model_reset();
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(8'h18);
    chk("rr_restart", 32'(gnt[0]), 32'h08);
    repeat (3) cycle(8'h18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
